// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t      - responder FSM encoding (IDLE / WAIT / RESP)
//   F3_*         - Funct3M access size/sign encodings
//   access_bad   - rejects illegal or misaligned requests
//   lane_mask    - byte-lane enables for a given size and address offset
//   store_align  - replicates right-aligned store data onto every lane
//   load_extend  - selects the addressed lanes of a word and extends them
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads, so a store with 1xx is illegal.
    function automatic logic access_bad(input logic       write,
                                        input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = lo[0];
            F3_W:    bad = (lo != 2'b00);
            F3_BU:   bad = write;
            F3_HU:   bad = write | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3,
                                             input logic [1:0] lo);
        logic [3:0] mask;
        case (f3[1:0])
            2'b00:   mask = 4'b0001 << lo;
            2'b01:   mask = lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // With the data copied onto every lane, the lane mask alone picks
    // the bytes that land in the array.
    function automatic logic [31:0] store_align(input logic [2:0]  f3,
                                                input logic [31:0] data);
        logic [31:0] word;
        case (f3[1:0])
            2'b00:   word = {4{data[7:0]}};
            2'b01:   word = {2{data[15:0]}};
            default: word = data;
        endcase
        return word;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'd0, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU memory-stage port toward the data-memory responder.
//   master : CPU side  - drives the request, receives the response
//   slave  : responder - receives the request, drives the response
// Request : MemReqM, MemWriteM, ALUResultM[31:0], WriteDataM[31:0], Funct3M[2:0]
// Response: ReadData[31:0], MemReady, AccessErr
interface dmem_responder_if;
    logic        MemReqM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  Funct3M;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        AccessErr;

    modport master (
        output MemReqM, MemWriteM, ALUResultM, WriteDataM, Funct3M,
        input  ReadData, MemReady, AccessErr
    );

    modport slave (
        input  MemReqM, MemWriteM, ALUResultM, WriteDataM, Funct3M,
        output ReadData, MemReady, AccessErr
    );
endinterface

// File: rtl/dmem_responder_ram.sv
// Single-port data array, DEPTH_WORDS x 32, with byte write enables.
// The read is registered: rdata shows the word at addr as it was before
// any write performed on the same edge. The array is never reset.
//   clk   in   clock
//   we    in   [3:0] byte-lane write enables
//   addr  in   word index
//   wdata in   [31:0] write data, lane i in bits [8i+7:8i]
//   rdata out  [31:0] registered read data
module dmem_ram #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time from the CPU's
// memory stage, waits WAIT_CYCLES, performs a little-endian b/h/w access
// and returns a one-cycle MemReady (with ReadData for loads, AccessErr on
// rejected requests).
//   clk    in   clock
//   reset  in   asynchronous, active-high reset
//   bus    slave side of dmem_responder_if
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for MemReqM; request fields latched on acceptance
// WAIT    | wait states; down-counter runs to zero, then access happens
// RESP    | MemReady pulse; array access already done on entry
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t        state;
    state_t        state_next;
    logic [3:0]    wait_cnt;

    logic          write_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;

    logic          cur_write;
    logic [2:0]    cur_f3;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;

    logic          enter_resp;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_q;

    logic          mem_ready;
    logic          access_err;
    logic [31:0]   read_data;

    // Upper address bits only alias; they take no part in the access.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^bus.ALUResultM[31:AW+2];

    // With no wait states the access happens on the acceptance edge itself,
    // before the latched copy exists, so IDLE looks at the live request.
    assign cur_write = (state == ST_IDLE) ? bus.MemWriteM           : write_q;
    assign cur_f3    = (state == ST_IDLE) ? bus.Funct3M             : f3_q;
    assign cur_addr  = (state == ST_IDLE) ? bus.ALUResultM[AW+1:0]  : addr_q;
    assign cur_wdata = (state == ST_IDLE) ? bus.WriteDataM          : wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.MemReqM) begin
                    state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_ready  = (state == ST_RESP);
        access_err = mem_ready && access_bad(write_q, f3_q, addr_q[1:0]);
        read_data  = 32'd0;
        if (mem_ready && !access_err && !write_q) begin
            read_data = load_extend(f3_q, addr_q[1:0], ram_q);
        end
    end

    assign bus.MemReady  = mem_ready;
    assign bus.AccessErr = access_err;
    assign bus.ReadData  = read_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (state == ST_IDLE && state_next == ST_WAIT) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else if (state == ST_IDLE && bus.MemReqM) begin
            write_q <= bus.MemWriteM;
            f3_q    <= bus.Funct3M;
            addr_q  <= bus.ALUResultM[AW+1:0];
            wdata_q <= bus.WriteDataM;
        end
    end

    // RESP is never its own successor, so state_next alone marks the entry edge.
    // The array is unreset, so a clock edge while reset is held must not write.
    assign enter_resp = (state_next == ST_RESP);
    assign ram_wdata  = store_align(cur_f3, cur_wdata);
    assign ram_we     = (enter_resp && cur_write && !reset &&
                         !access_bad(cur_write, cur_f3, cur_addr[1:0]))
                        ? lane_mask(cur_f3, cur_addr[1:0]) : 4'b0000;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (cur_addr[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: dut1 has one wait state, dut0 none.
// Requests push their hand-computed response; per-DUT monitors pop and
// compare whenever MemReady is seen.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic clk;
    logic rst1;
    logic rst0;

    int tests = 0;
    int fails = 0;

    exp_t sb1[$];
    exp_t sb0[$];
    exp_t e1;
    exp_t e0;

    dmem_responder_if if1 ();
    dmem_responder_if if0 ();

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1.slave)
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic drive(input int d, input logic req, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (d == 1) begin
            if1.MemReqM = req; if1.MemWriteM = wr; if1.Funct3M = f3;
            if1.ALUResultM = addr; if1.WriteDataM = wd;
        end else begin
            if0.MemReqM = req; if0.MemWriteM = wr; if0.Funct3M = f3;
            if0.ALUResultM = addr; if0.WriteDataM = wd;
        end
    endtask

    task automatic push(input int d, input logic [31:0] rd, input logic err, input string nm);
        exp_t e;
        e.rdata = rd;
        e.err   = err;
        e.name  = nm;
        if (d == 1) sb1.push_back(e);
        else        sb0.push_back(e);
    endtask

    function automatic logic rdy(input int d);
        return (d == 1) ? if1.MemReady : if0.MemReady;
    endfunction

    // Called at a falling edge; returns at the falling edge after the pulse.
    task automatic do_req(input int d, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee, input string nm);
        int lat;
        int want;
        want = (d == 1) ? 2 : 1;
        push(d, er, ee, nm);
        drive(d, 1'b1, wr, f3, addr, wd);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rdy(d) !== 1'b1 && lat < 20);
        check({nm, "_latency"}, 32'(lat), 32'(want));
        drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        check({nm, "_pulse_width"}, 32'(rdy(d)), 32'd0);
    endtask

    always @(negedge clk) begin
        if (if1.MemReady === 1'b1) begin
            if (sb1.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut1_unexpected_resp got MemReady=1 want no response");
            end else begin
                e1 = sb1.pop_front();
                check({e1.name, "_rdata"}, if1.ReadData, e1.rdata);
                check({e1.name, "_err"}, 32'(if1.AccessErr), 32'(e1.err));
            end
        end else begin
            check("dut1_err_idle", 32'(if1.AccessErr), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (if0.MemReady === 1'b1) begin
            if (sb0.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut0_unexpected_resp got MemReady=1 want no response");
            end else begin
                e0 = sb0.pop_front();
                check({e0.name, "_rdata"}, if0.ReadData, e0.rdata);
                check({e0.name, "_err"}, 32'(if0.AccessErr), 32'(e0.err));
            end
        end else begin
            check("dut0_err_idle", 32'(if0.AccessErr), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst1 = 1'b1;
        rst0 = 1'b1;
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_ready1", 32'(if1.MemReady), 32'd0);
        check("rst_rdata1", if1.ReadData, 32'd0);
        check("rst_ready0", 32'(if0.MemReady), 32'd0);
        check("rst_rdata0", if0.ReadData, 32'd0);
        rst1 = 1'b0;
        rst0 = 1'b0;
        @(negedge clk);

        // word store/load, sub-word loads
        do_req(1, 1'b1, F3_W,  32'd132, 32'hABCDE02E, 32'h00000000, 1'b0, "sw132");
        do_req(1, 1'b0, F3_W,  32'd132, 32'd0,        32'hABCDE02E, 1'b0, "lw132");
        do_req(1, 1'b0, F3_B,  32'd132, 32'd0,        32'h0000002E, 1'b0, "lb132");
        do_req(1, 1'b0, F3_B,  32'd135, 32'd0,        32'hFFFFFFAB, 1'b0, "lb135");
        do_req(1, 1'b0, F3_HU, 32'd134, 32'd0,        32'h0000ABCD, 1'b0, "lhu134");
        do_req(1, 1'b0, F3_H,  32'd132, 32'd0,        32'hFFFFE02E, 1'b0, "lh132");
        do_req(1, 1'b0, F3_BU, 32'd133, 32'd0,        32'h000000E0, 1'b0, "lbu133");

        // sub-word stores touch only their lanes
        do_req(1, 1'b1, F3_B,  32'd133, 32'h000000FF, 32'h00000000, 1'b0, "sb133");
        do_req(1, 1'b0, F3_W,  32'd132, 32'd0,        32'hABCDFF2E, 1'b0, "lw132_after_sb");
        do_req(1, 1'b1, F3_H,  32'd134, 32'h00005A5A, 32'h00000000, 1'b0, "sh134");
        do_req(1, 1'b0, F3_W,  32'd132, 32'd0,        32'h5A5AFF2E, 1'b0, "lw132_after_sh");

        // rejected requests
        do_req(1, 1'b1, F3_W,  32'd128, 32'h11223344, 32'h00000000, 1'b0, "sw128");
        do_req(1, 1'b1, F3_W,  32'd130, 32'hDEADBEEF, 32'h00000000, 1'b1, "sw130_misalign");
        do_req(1, 1'b1, F3_BU, 32'd128, 32'h000000AA, 32'h00000000, 1'b1, "sbu_illegal");
        do_req(1, 1'b0, 3'b011, 32'd128, 32'd0,       32'h00000000, 1'b1, "ld_f3_011");
        do_req(1, 1'b0, F3_H,  32'd129, 32'd0,        32'h00000000, 1'b1, "lh129_misalign");
        do_req(1, 1'b0, F3_W,  32'd128, 32'd0,        32'h11223344, 1'b0, "lw128_unchanged");

        // reset during WAIT discards the store
        drive(1, 1'b1, 1'b1, F3_W, 32'd132, 32'h12345678);
        @(negedge clk);
        #1 rst1 = 1'b1;
        #1 check("rst_wait_ready", 32'(if1.MemReady), 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #2 rst1 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_wait_no_ready", 32'(if1.MemReady), 32'd0);
        end
        do_req(1, 1'b0, F3_W,  32'd132, 32'd0,        32'h5A5AFF2E, 1'b0, "lw132_after_rst");

        // reset during RESP: write stands, outputs clear at once
        push(1, 32'd0, 1'b0, "sw136_resp_rst");
        drive(1, 1'b1, 1'b1, F3_W, 32'd136, 32'hCAFEF00D);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (if1.MemReady !== 1'b1 && lat < 20);
        check("sw136_latency", 32'(lat), 32'd2);
        #1 rst1 = 1'b1;
        #1 check("rst_resp_ready_async", 32'(if1.MemReady), 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #2 rst1 = 1'b0;
        @(negedge clk);
        do_req(1, 1'b0, F3_W,  32'd136, 32'd0,        32'hCAFEF00D, 1'b0, "lw136_after_rst");

        // zero wait states, back-to-back with request held high
        push(0, 32'd0, 1'b0, "b2b_sw0");
        push(0, 32'd0, 1'b0, "b2b_sw4");
        drive(0, 1'b1, 1'b1, F3_W, 32'd0, 32'h0BADF00D);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (if0.MemReady !== 1'b1 && lat < 20);
        check("b2b_first_latency", 32'(lat), 32'd1);
        drive(0, 1'b1, 1'b1, F3_W, 32'd4, 32'h600DCAFE);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (if0.MemReady !== 1'b1 && lat < 20);
        check("b2b_gap", 32'(lat), 32'd2);
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("b2b_pulse_width", 32'(if0.MemReady), 32'd0);
        do_req(0, 1'b0, F3_W,  32'd256, 32'd0,        32'h0BADF00D, 1'b0, "lw256_alias");
        do_req(0, 1'b0, F3_W,  32'd4,   32'd0,        32'h600DCAFE, 1'b0, "lw4");
        do_req(0, 1'b1, F3_B,  32'd259, 32'h00000077, 32'h00000000, 1'b0, "sb259_alias");
        do_req(0, 1'b0, F3_W,  32'd0,   32'd0,        32'h77ADF00D, 1'b0, "lw0_after_alias");
        do_req(0, 1'b0, F3_H,  32'd1,   32'd0,        32'h00000000, 1'b1, "lh1_misalign_w0");

        repeat (2) @(negedge clk);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        check("sb0_drained", 32'(sb0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
